// File: rtl/mips32_pipeline_hz.sv
// mips32_pipeline_hz: 5-stage MIPS32 core with forwarding/interlock, branch flush and stallable data port
// Build with MIPS32_FWD_EN defined to enable EX-stage operand forwarding.
module mips32_pipeline_hz #(
  parameter int          DATA_W   = 32,
  parameter int          NREG     = 32,
  parameter int          IADDR_W  = 10,
  parameter int          DADDR_W  = 10,
  parameter int unsigned RESET_PC = 0
) (
  input  logic               clk,
  input  logic               rst_n,
  output logic [IADDR_W-1:0] imem_addr,
  input  logic [31:0]        imem_rdata,
  output logic               dmem_req,
  output logic               dmem_we,
  output logic [DADDR_W-1:0] dmem_addr,
  output logic [DATA_W-1:0]  dmem_wdata,
  input  logic [DATA_W-1:0]  dmem_rdata,
  input  logic               dmem_ready,
  output logic               halted,
  output logic               retire_valid
);
`ifdef MIPS32_FWD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif
  localparam logic [5:0] OP_ADD = 6'b000000, OP_SUB = 6'b000001, OP_AND = 6'b000010, OP_OR = 6'b000011;
  localparam logic [5:0] OP_SLT = 6'b000100, OP_MUL = 6'b000101, OP_LW = 6'b001000, OP_SW = 6'b001001;
  localparam logic [5:0] OP_ADDI = 6'b001010, OP_SUBI = 6'b001011, OP_SLTI = 6'b001100;
  localparam logic [5:0] OP_BNEQZ = 6'b001101, OP_BEQZ = 6'b001110;

  function automatic logic is_rr(input logic [5:0] op);
    return op <= OP_MUL;
  endfunction
  function automatic logic is_rm(input logic [5:0] op);
    return op inside {OP_ADDI, OP_SUBI, OP_SLTI};
  endfunction
  function automatic logic is_br(input logic [5:0] op);
    return op inside {OP_BNEQZ, OP_BEQZ};
  endfunction
  function automatic logic is_hlt(input logic [5:0] op);
    return !(is_rr(op) || is_rm(op) || is_br(op) || op == OP_LW || op == OP_SW);
  endfunction
  function automatic logic uses(input logic [5:0] op, input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] r);
    return (!is_hlt(op) && rs == r) || ((is_rr(op) || op == OP_SW) && rt == r);
  endfunction

  logic [IADDR_W-1:0] pc, fd_npc, de_npc, target;
  logic               fd_valid, de_valid, em_valid, mw_valid;
  logic [31:0]        fd_ir, de_ir;
  logic [DATA_W-1:0]  de_a, de_b, em_alu, em_b, mw_res, id_a, id_b, fa, fb, imm, alu;
  logic               em_lw, em_sw, em_hlt, em_wen, mw_hlt, mw_wen;
  logic [4:0]         em_dst, mw_dst, d_dst, f_rs, f_rt, d_rs, d_rt;
  logic [5:0]         f_op, d_op;
  logic               d_wen, take, stall, hz, hstop, wb_we;
  logic [DATA_W-1:0]  rf [32];

  assign {f_op, f_rs, f_rt} = fd_ir[31:16];
  assign {d_op, d_rs, d_rt} = de_ir[31:16];
  assign d_dst = is_rr(d_op) ? de_ir[15:11] : d_rt;
  assign d_wen = (is_rr(d_op) || is_rm(d_op) || d_op == OP_LW) && d_dst != 5'd0 && int'(d_dst) < NREG;

  assign imem_addr    = pc;
  assign dmem_req     = em_valid && (em_lw || em_sw) && !halted;
  assign dmem_we      = em_sw;
  assign dmem_addr    = em_alu[DADDR_W-1:0];
  assign dmem_wdata   = em_b;
  assign retire_valid = mw_valid && !halted;
  assign wb_we        = retire_valid && mw_wen;

  // write-through read: ID sees the value WB is writing this cycle
  assign id_a = (wb_we && mw_dst == f_rs) ? mw_res : rf[f_rs];
  assign id_b = (wb_we && mw_dst == f_rt) ? mw_res : rf[f_rt];
  // a load in EX/MEM never feeds forwarding: the interlock keeps its consumer out of EX
  assign fa = (FWD && em_valid && em_wen && !em_lw && em_dst == d_rs) ? em_alu :
              (FWD && wb_we && mw_dst == d_rs) ? mw_res : de_a;
  assign fb = (FWD && em_valid && em_wen && !em_lw && em_dst == d_rt) ? em_alu :
              (FWD && wb_we && mw_dst == d_rt) ? mw_res : de_b;

  assign imm    = {{(DATA_W-16){de_ir[15]}}, de_ir[15:0]};
  assign target = de_npc + imm[IADDR_W-1:0];
  assign take   = de_valid && is_br(d_op) && ((d_op == OP_BEQZ) == (fa == '0));
  assign stall  = dmem_req && !dmem_ready;
  assign hz     = fd_valid && ((de_valid && d_wen && (!FWD || d_op == OP_LW) && uses(f_op, f_rs, f_rt, d_dst)) ||
                               (!FWD && em_valid && em_wen && uses(f_op, f_rs, f_rt, em_dst)));
  // fetch stays stopped while any HLT is in flight
  assign hstop  = (fd_valid && is_hlt(f_op)) || (de_valid && is_hlt(d_op)) || (em_valid && em_hlt) || (mw_valid && mw_hlt);

  always_comb begin
    alu = fa + imm;
    case (d_op)
      OP_ADD:  alu = fa + fb;
      OP_SUB:  alu = fa - fb;
      OP_AND:  alu = fa & fb;
      OP_OR:   alu = fa | fb;
      OP_SLT:  alu = DATA_W'($signed(fa) < $signed(fb));
      OP_MUL:  alu = fa * fb;
      OP_SUBI: alu = fa - imm;
      OP_SLTI: alu = DATA_W'($signed(fa) < $signed(imm));
      default: alu = fa + imm;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) rf <= '{default: '0};
    else if (wb_we) rf[mw_dst] <= mw_res;

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      pc       <= IADDR_W'(RESET_PC);
      halted   <= 1'b0;
      fd_valid <= 1'b0;
      de_valid <= 1'b0;
      em_valid <= 1'b0;
      mw_valid <= 1'b0;
      fd_ir    <= '0;
      fd_npc   <= '0;
      de_ir    <= '0;
      de_npc   <= '0;
      de_a     <= '0;
      de_b     <= '0;
      em_alu   <= '0;
      em_b     <= '0;
      em_lw    <= 1'b0;
      em_sw    <= 1'b0;
      em_hlt   <= 1'b0;
      em_wen   <= 1'b0;
      em_dst   <= '0;
      mw_res   <= '0;
      mw_hlt   <= 1'b0;
      mw_wen   <= 1'b0;
      mw_dst   <= '0;
    end else if (!halted) begin
      halted <= mw_valid && mw_hlt;
      if (stall) begin
        mw_valid <= 1'b0;
        de_a     <= fa;
        de_b     <= fb;
      end else begin
        mw_valid <= em_valid;
        mw_res   <= em_lw ? dmem_rdata : em_alu;
        mw_hlt   <= em_hlt;
        mw_wen   <= em_wen;
        mw_dst   <= em_dst;
        em_valid <= de_valid;
        em_alu   <= alu;
        em_b     <= fb;
        em_lw    <= d_op == OP_LW;
        em_sw    <= d_op == OP_SW;
        em_hlt   <= is_hlt(d_op);
        em_wen   <= d_wen;
        em_dst   <= d_dst;
        if (take) begin
          pc       <= target;
          fd_valid <= 1'b0;
          de_valid <= 1'b0;
        end else if (hz) begin
          de_valid <= 1'b0;
        end else begin
          de_valid <= fd_valid;
          de_ir    <= fd_ir;
          de_npc   <= fd_npc;
          de_a     <= id_a;
          de_b     <= id_b;
          if (hstop) fd_valid <= 1'b0;
          else begin
            pc       <= pc + 1'b1;
            fd_valid <= 1'b1;
            fd_ir    <= imem_rdata;
            fd_npc   <= pc + 1'b1;
          end
        end
      end
    end
endmodule

// File: tb/tb_mips32_pipeline_hz.sv
// tb_mips32_pipeline_hz: directed programs against mips32_pipeline_hz with external imem/dmem models
module tb_mips32_pipeline_hz;
  localparam logic [5:0] OP_ADD = 6'b000000, OP_SUB = 6'b000001, OP_AND = 6'b000010, OP_OR = 6'b000011;
  localparam logic [5:0] OP_SLT = 6'b000100, OP_MUL = 6'b000101, OP_LW = 6'b001000, OP_SW = 6'b001001;
  localparam logic [5:0] OP_ADDI = 6'b001010, OP_SUBI = 6'b001011, OP_SLTI = 6'b001100;
  localparam logic [5:0] OP_BNEQZ = 6'b001101, OP_BEQZ = 6'b001110;
  localparam logic [31:0] HLT_W = 32'hFC00_0000;
`ifdef MIPS32_FWD_EN
  localparam int GAP_A = 2, GAP_B = 2;
`else
  localparam int GAP_A = 4, GAP_B = 3;
`endif

  logic        clk = 1'b0, rst_n = 1'b1;
  logic [9:0]  imem_addr, dmem_addr;
  logic [31:0] imem_rdata, dmem_wdata, dmem_rdata;
  logic        dmem_req, dmem_we, dmem_ready, halted, retire_valid;

  logic [31:0] imem [1024];
  logic [31:0] wmem [1024];
  bit          wr [1024];
  int          ready_delay = 0, age, n_st, cyc, n_ret, n_req, n_reqok;
  int          rt [8];
  int          n_chk = 0, n_fail = 0;

  mips32_pipeline_hz dut (
    .clk(clk), .rst_n(rst_n), .imem_addr(imem_addr), .imem_rdata(imem_rdata),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
    .dmem_rdata(dmem_rdata), .dmem_ready(dmem_ready), .halted(halted), .retire_valid(retire_valid)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] init_val(input logic [9:0] a);
    return a == 10'd0 ? 32'd9 : a == 10'd1 ? 32'h7FFF_FFFF : 32'hDEAD_0000 | 32'(a);
  endfunction
  function automatic logic [31:0] mem_at(input int a);
    return wr[a] ? wmem[a] : init_val(10'(a));
  endfunction
  function automatic logic [31:0] r3(input logic [5:0] op, input int rd, input int rs, input int rt_);
    return {op, 5'(rs), 5'(rt_), 5'(rd), 11'd0};
  endfunction
  function automatic logic [31:0] ri(input logic [5:0] op, input int rt_, input int rs, input int imm);
    return {op, 5'(rs), 5'(rt_), 16'(imm)};
  endfunction

  assign imem_rdata = imem[imem_addr];
  assign dmem_rdata = wr[dmem_addr] ? wmem[dmem_addr] : init_val(dmem_addr);
  assign dmem_ready = age >= ready_delay;

  always @(posedge clk)
    if (!rst_n) begin
      wr   <= '{default: 1'b0};
      age  <= 0;
      n_st <= 0;
    end else begin
      age <= (dmem_req && !dmem_ready) ? age + 1 : 0;
      if (dmem_req && dmem_ready && dmem_we) begin
        wr[dmem_addr]   <= 1'b1;
        wmem[dmem_addr] <= dmem_wdata;
        n_st            <= n_st + 1;
      end
    end

  always @(negedge clk)
    if (!rst_n) begin
      cyc     <= 0;
      n_ret   <= 0;
      n_req   <= 0;
      n_reqok <= 0;
    end else begin
      cyc <= cyc + 1;
      if (retire_valid) begin
        if (n_ret < 8) rt[n_ret] <= cyc;
        n_ret <= n_ret + 1;
      end
      if (dmem_req) n_req <= n_req + 1;
      if (dmem_req && dmem_we && dmem_addr == 10'd4 && dmem_wdata == 32'd7) n_reqok <= n_reqok + 1;
    end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic clr();
    for (int i = 0; i < 1024; i++) imem[i] = HLT_W;
  endtask

  task automatic run(input string tag);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 300 && !halted; i++) @(negedge clk);
    check({tag, "_halted"}, 32'(halted), 32'd1);
    repeat (10) @(negedge clk);
  endtask

  initial begin
    clr();
    #1 rst_n = 1'b0;
    #2;
    check("rst_pc", 32'(imem_addr), 32'd0);
    check("rst_req", 32'(dmem_req), 32'd0);
    check("rst_ret", 32'(retire_valid), 32'd0);
    check("rst_halt", 32'(halted), 32'd0);

    clr();
    imem[0] = ri(OP_ADDI, 1, 0, 5);
    imem[1] = ri(OP_ADDI, 2, 0, 7);
    imem[2] = r3(OP_ADD, 3, 1, 2);
    imem[3] = ri(OP_SW, 3, 0, 100);
    run("a");
    check("a_r3", mem_at(100), 32'd12);
    check("a_gap", 32'(rt[2] - rt[0]), 32'(GAP_A));
    check("a_nret", 32'(n_ret), 32'd5);

    clr();
    imem[0] = ri(OP_LW, 4, 0, 0);
    imem[1] = r3(OP_ADD, 5, 4, 4);
    imem[2] = ri(OP_SW, 5, 0, 101);
    run("b");
    check("b_r5", mem_at(101), 32'd18);
    check("b_gap", 32'(rt[1] - rt[0]), 32'(GAP_B));

    for (int k = 0; k < 2; k++) begin
      clr();
      imem[0] = ri(OP_ADDI, 1, 0, 0);
      imem[1] = ri(k == 0 ? OP_BEQZ : OP_BNEQZ, 0, 1, 2);
      imem[2] = ri(OP_ADDI, 6, 0, 1);
      imem[3] = ri(OP_ADDI, 7, 0, 1);
      imem[4] = ri(OP_ADDI, 8, 0, 3);
      imem[5] = ri(OP_SW, 6, 0, 102);
      imem[6] = ri(OP_SW, 7, 0, 103);
      imem[7] = ri(OP_SW, 8, 0, 104);
      run(k == 0 ? "beqz" : "bneqz");
      check(k == 0 ? "beqz_r6" : "bneqz_r6", mem_at(102), k == 0 ? 32'd0 : 32'd1);
      check(k == 0 ? "beqz_r7" : "bneqz_r7", mem_at(103), k == 0 ? 32'd0 : 32'd1);
      check(k == 0 ? "beqz_r8" : "bneqz_r8", mem_at(104), 32'd3);
      check(k == 0 ? "beqz_nret" : "bneqz_nret", 32'(n_ret), k == 0 ? 32'd7 : 32'd9);
    end

    clr();
    imem[0] = ri(OP_ADDI, 2, 0, 7);
    imem[1] = ri(OP_SW, 2, 0, 4);
    ready_delay = 3;
    run("e");
    ready_delay = 0;
    check("e_mem", mem_at(4), 32'd7);
    check("e_nreq", 32'(n_req), 32'd4);
    check("e_held", 32'(n_reqok), 32'd4);
    check("e_nst", 32'(n_st), 32'd1);
    check("e_nret", 32'(n_ret), 32'd3);

    clr();
    imem[0] = ri(OP_ADDI, 2, 0, 7);
    imem[1] = HLT_W;
    imem[2] = ri(OP_SW, 2, 0, 8);
    run("f");
    check("f_mem8", mem_at(8), init_val(10'd8));
    check("f_nret", 32'(n_ret), 32'd2);
    check("f_nreq", 32'(n_req), 32'd0);
    check("f_pc", 32'(imem_addr), 32'd2);

    clr();
    imem[0] = ri(OP_SLTI, 9, 0, -1);
    imem[1] = ri(OP_LW, 10, 0, 1);
    imem[2] = ri(OP_ADDI, 11, 10, 1);
    imem[3] = ri(OP_SW, 9, 0, 105);
    imem[4] = ri(OP_SW, 11, 0, 106);
    imem[5] = 32'h4000_0000;
    imem[6] = ri(OP_SW, 11, 0, 107);
    run("g");
    check("g_slti", mem_at(105), 32'd0);
    check("g_wrap", mem_at(106), 32'h8000_0000);
    check("g_inv", mem_at(107), init_val(10'd107));
    check("g_nret", 32'(n_ret), 32'd6);

    clr();
    imem[0] = ri(OP_ADDI, 1, 0, -3);
    imem[1] = ri(OP_ADDI, 2, 0, 6);
    imem[2] = r3(OP_SUB, 3, 1, 2);
    imem[3] = r3(OP_AND, 4, 1, 2);
    imem[4] = r3(OP_OR, 5, 1, 2);
    imem[5] = r3(OP_SLT, 6, 1, 2);
    imem[6] = r3(OP_MUL, 7, 1, 2);
    imem[7] = ri(OP_SUBI, 8, 2, 10);
    for (int i = 0; i < 6; i++) imem[8 + i] = ri(OP_SW, 3 + i, 0, 110 + i);
    run("h");
    check("h_sub", mem_at(110), 32'hFFFF_FFF7);
    check("h_and", mem_at(111), 32'd4);
    check("h_or", mem_at(112), 32'hFFFF_FFFF);
    check("h_slt", mem_at(113), 32'd1);
    check("h_mul", mem_at(114), 32'hFFFF_FFEE);
    check("h_subi", mem_at(115), 32'hFFFF_FFFC);

    clr();
    imem[0] = ri(OP_ADDI, 2, 0, 7);
    imem[1] = ri(OP_SW, 2, 0, 4);
    ready_delay = 1000;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 50 && !dmem_req; i++) @(negedge clk);
    check("mr_req", 32'(dmem_req), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("mr_drop", 32'(dmem_req), 32'd0);
    check("mr_nost", 32'(n_st), 32'd0);
    check("mr_pc", 32'(imem_addr), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
